reg_pipe: RTL



---
 rtl/reg_pipe_if.sv | 21 ++
 rtl/reg_pipe.sv | 89 ++++++++
 2 files changed

// File: rtl/reg_pipe_if.sv
// rtl/reg_pipe_if.sv - valid/ready handshake bundle for reg_pipe (input and output sides)
interface reg_pipe_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/reg_pipe.sv
// rtl/reg_pipe.sv - elastic pipeline register: DEPTH stages of N bits with valid/ready handshake
// Optional build macro REG_PIPE_ZERO_EN: stages that go empty also clear their data to 0.
module reg_pipe #(
  parameter  int N     = 8,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          flush,
  reg_pipe_if.slave     bus,
  output logic [CW-1:0] count
);

  logic [N-1:0]     data_q [DEPTH];
  logic [N-1:0]     src    [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic             room;
  logic             accept;
  logic             xfer;

  // Walk from the output side: a stage advances when the stage ahead has room.
  always_comb begin
    adv  = '0;
    room = bus.out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k] = v_q[k] & room;
      room   = !v_q[k] | room;
    end
  end

  assign bus.in_ready  = !flush & room;
  assign accept        = bus.in_valid & bus.in_ready;
  assign xfer          = adv[DEPTH-1];
  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.out_data  = data_q[DEPTH-1];

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_src
      if (g == 0) begin : g_first
        assign src[g]  = bus.in_data;
        assign load[g] = accept;
      end else begin : g_rest
        assign src[g]  = data_q[g-1];
        assign load[g] = adv[g-1] & !flush;
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v_q   <= '0;
      count <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      if (flush) begin
        count <= '0;
      end else begin
        count <= count + CW'(accept) - CW'(xfer);
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (flush) begin
          v_q[k] <= 1'b0;
        end else if (load[k]) begin
          v_q[k] <= 1'b1;
        end else if (adv[k]) begin
          v_q[k] <= 1'b0;
        end
`ifdef REG_PIPE_ZERO_EN
        if (load[k]) begin
          data_q[k] <= src[k];
        end else if (flush || adv[k]) begin
          data_q[k] <= '0;
        end
`else
        if (load[k]) begin
          data_q[k] <= src[k];
        end
`endif
      end
    end
  end

endmodule
